bf_core_stacked: RTL and testbench

Parametrised successor to the brainfuck processor core. It executes brainfuck from a code RAM against a separate array RAM, like the first-generation core, but adds four things:
- configurable cell width;
- a hardware loop-return stack, so `]` jumps back in a single step instead of scanning backwards;
- valid/ready handshakes on character I/O;
- explicit error reporting.

It sits between the code/array RAM blocks and the UART parallel interface.

---
 rtl/bf_core_stacked.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_bf_core_stacked.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_core_stacked.sv
// Brainfuck core with a hardware loop-return stack, parametric cell width and handshaked I/O.
// Optional BF_ARRAY_WRAP_EN: the array pointer wraps at the ends instead of raising error.
module bf_core_stacked #(
    parameter int unsigned CELL_WIDTH  = 8,
    parameter int unsigned ADDR_ARRAY  = 9,
    parameter int unsigned ADDR_CODE   = 9,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_CODE-1:0]         addr_code,
    input  logic [7:0]                   data_code,
    output logic [ADDR_ARRAY-1:0]        addr_array,
    input  logic [CELL_WIDTH-1:0]        dataIn_array,
    output logic [CELL_WIDTH-1:0]        dataOut_array,
    output logic                         writeRq_array,
    output logic                         tx_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready,
    output logic                         rx_ready,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(STACK_DEPTH):0] loop_depth
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        FETCH, EXEC, LOAD1, LOAD2, SKIP, TX, RX, HALT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_CODE-1:0]    pc_q, pc_d;
    logic [ADDR_ARRAY-1:0]   ptr_q, ptr_d;
    logic [CELL_WIDTH-1:0]   cell_q, cell_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [ADDR_CODE-1:0]    nest_q, nest_d;
    logic                    skip_wait_q, skip_wait_d;
    logic                    wr_q, wr_d;
    logic                    txv_q, txv_d;
    logic [7:0]              txd_q, txd_d;
    logic                    rxr_q, rxr_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [ADDR_CODE-1:0]    stack_q [STACK_DEPTH];
    logic                    push_en;
    logic                    adv;
    logic [SP_W-1:0]         sp_m1;
    logic [ADDR_CODE-1:0]    stack_top;

    assign sp_m1     = sp_q - SP_W'(1);
    assign stack_top = stack_q[sp_m1[IDX_W-1:0]];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        cell_d      = cell_q;
        sp_d        = sp_q;
        nest_d      = nest_q;
        skip_wait_d = skip_wait_q;
        wr_d        = 1'b0;
        txv_d       = txv_q;
        txd_d       = txd_q;
        rxr_d       = rxr_q;
        done_d      = done_q;
        err_d       = err_q;
        push_en     = 1'b0;
        adv         = 1'b0;

        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                case (data_code)
                    8'h2B: begin
                        cell_d = cell_q + CELL_WIDTH'(1);
                        wr_d   = 1'b1;
                        adv    = 1'b1;
                    end
                    8'h2D: begin
                        cell_d = cell_q - CELL_WIDTH'(1);
                        wr_d   = 1'b1;
                        adv    = 1'b1;
                    end
                    8'h3E: begin
`ifdef BF_ARRAY_WRAP_EN
                        ptr_d   = ptr_q + ADDR_ARRAY'(1);
                        state_d = LOAD1;
                        adv     = 1'b1;
`else
                        if (&ptr_q) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            ptr_d   = ptr_q + ADDR_ARRAY'(1);
                            state_d = LOAD1;
                            adv     = 1'b1;
                        end
`endif
                    end
                    8'h3C: begin
`ifdef BF_ARRAY_WRAP_EN
                        ptr_d   = ptr_q - ADDR_ARRAY'(1);
                        state_d = LOAD1;
                        adv     = 1'b1;
`else
                        if (ptr_q == '0) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            ptr_d   = ptr_q - ADDR_ARRAY'(1);
                            state_d = LOAD1;
                            adv     = 1'b1;
                        end
`endif
                    end
                    8'h5B: begin
                        if (cell_q != '0) begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                err_d   = 1'b1;
                                state_d = HALT;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                adv     = 1'b1;
                            end
                        end else begin
                            nest_d      = '0;
                            skip_wait_d = 1'b1;
                            state_d     = SKIP;
                            adv         = 1'b1;
                        end
                    end
                    8'h5D: begin
                        if (sp_q == '0) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else if (cell_q != '0) begin
                            pc_d = stack_top;
                        end else begin
                            sp_d = sp_m1;
                            adv  = 1'b1;
                        end
                    end
                    8'h2E: begin
                        txv_d   = 1'b1;
                        txd_d   = 8'(cell_q);
                        state_d = TX;
                    end
                    8'h2C: begin
                        rxr_d   = 1'b1;
                        state_d = RX;
                    end
                    8'h00: begin
                        done_d  = 1'b1;
                        state_d = HALT;
                    end
                    default: adv = 1'b1;
                endcase
            end
            LOAD1: state_d = LOAD2;
            LOAD2: begin
                cell_d  = dataIn_array;
                state_d = FETCH;
            end
            SKIP: begin
                // Alternate wait/decode cycles so every scanned byte sees fresh fetch data.
                if (skip_wait_q) begin
                    skip_wait_d = 1'b0;
                end else begin
                    skip_wait_d = 1'b1;
                    adv         = 1'b1;
                    case (data_code)
                        8'h5B: nest_d = nest_q + ADDR_CODE'(1);
                        8'h5D: begin
                            if (nest_q == '0) begin
                                state_d     = FETCH;
                                skip_wait_d = 1'b0;
                            end else begin
                                nest_d = nest_q - ADDR_CODE'(1);
                            end
                        end
                        8'h00: begin
                            adv     = 1'b0;
                            err_d   = 1'b1;
                            state_d = HALT;
                        end
                        default: ;
                    endcase
                end
            end
            TX: begin
                if (tx_ready) begin
                    txv_d   = 1'b0;
                    state_d = FETCH;
                    adv     = 1'b1;
                end
            end
            RX: begin
                if (rx_valid) begin
                    cell_d  = CELL_WIDTH'(rx_data);
                    wr_d    = 1'b1;
                    rxr_d   = 1'b0;
                    state_d = FETCH;
                    adv     = 1'b1;
                end
            end
            HALT: ;
            default: state_d = HALT;
        endcase

        // The program counter never wraps: stepping past the last code byte ends the run.
        if (adv) begin
            if (&pc_q) begin
                done_d  = 1'b1;
                state_d = HALT;
                push_en = 1'b0;
                sp_d    = sp_q;
            end else begin
                pc_d = pc_q + ADDR_CODE'(1);
            end
        end

        if (state_d == HALT) begin
            wr_d  = 1'b0;
            txv_d = 1'b0;
            rxr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ptr_q       <= '0;
            cell_q      <= '0;
            sp_q        <= '0;
            nest_q      <= '0;
            skip_wait_q <= 1'b0;
            wr_q        <= 1'b0;
            txv_q       <= 1'b0;
            txd_q       <= '0;
            rxr_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            cell_q      <= cell_d;
            sp_q        <= sp_d;
            nest_q      <= nest_d;
            skip_wait_q <= skip_wait_d;
            wr_q        <= wr_d;
            txv_q       <= txv_d;
            txd_q       <= txd_d;
            rxr_q       <= rxr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) stack_q[sp_q[IDX_W-1:0]] <= pc_q + ADDR_CODE'(1);
    end

    assign addr_code     = pc_q;
    assign addr_array    = ptr_q;
    assign dataOut_array = cell_q;
    assign writeRq_array = wr_q;
    assign tx_valid      = txv_q;
    assign tx_data       = txd_q;
    assign rx_ready      = rxr_q;
    assign done          = done_q;
    assign error         = err_q;
    assign loop_depth    = sp_q;

endmodule

// File: tb/tb_bf_core_stacked.sv
// Bench for bf_core_stacked: directed and random programs compared against a plain interpreter model.
`timescale 1ns/1ps
module tb_bf_core_stacked;
    localparam int CW   = 12;
    localparam int SD   = 2;
    localparam int MASK = (1 << CW) - 1;
`ifdef BF_ARRAY_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    addr_code;
    logic [7:0]    data_code;
    logic [8:0]    addr_array;
    logic [CW-1:0] dataIn_array;
    logic [CW-1:0] dataOut_array;
    logic          writeRq_array;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          rx_ready;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          done;
    logic          error;
    logic [1:0]    loop_depth;

    always #5 clk = ~clk;

    bf_core_stacked #(.CELL_WIDTH(CW), .ADDR_ARRAY(9), .ADDR_CODE(9), .STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset),
        .addr_code(addr_code), .data_code(data_code),
        .addr_array(addr_array), .dataIn_array(dataIn_array),
        .dataOut_array(dataOut_array), .writeRq_array(writeRq_array),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .done(done), .error(error), .loop_depth(loop_depth)
    );

    logic [7:0]    code_mem [512];
    logic [CW-1:0] arr_mem  [512];

    always @(posedge clk) data_code <= code_mem[addr_code];
    always @(posedge clk) begin
        dataIn_array <= arr_mem[addr_array];
        if (writeRq_array) arr_mem[addr_array] <= dataOut_array;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int in_bytes [16];
    int m_mem [512];
    int exp_tx[$], exp_wr[$], got_tx[$], got_wr[$];
    bit exp_done, exp_err, m_ok;
    int exp_sp, exp_maxsp, exp_ptr;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_prog(string s);
        for (int i = 0; i < 512; i++) code_mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) code_mem[i] = s[i];
    endtask

    task automatic init_env(bit rnd);
        for (int i = 0; i < 512; i++) arr_mem[i] = rnd ? CW'($urandom) : '0;
        for (int i = 0; i < 16; i++) in_bytes[i] = int'($urandom_range(0, 255));
    endtask

    // Reference interpreter: cell value, pointer, explicit return-stack queue, bracket scan.
    task automatic model_run();
        int pc, ptr, cur, steps, depth, p, idx;
        int stk[$];
        bit fin, scan;
        exp_tx.delete(); exp_wr.delete();
        exp_done = 0; exp_err = 0; exp_maxsp = 0; m_ok = 1;
        for (int i = 0; i < 512; i++) m_mem[i] = int'(arr_mem[i]);
        pc = 0; ptr = 0; cur = 0; steps = 0; idx = 0; fin = 0;
        while (!fin) begin
            if (steps > 150) begin
                m_ok = 0; fin = 1;
            end else begin
                steps++;
                case (code_mem[pc])
                    8'h2B: begin cur = (cur + 1) & MASK; m_mem[ptr] = cur; exp_wr.push_back(cur); pc++; end
                    8'h2D: begin cur = (cur - 1) & MASK; m_mem[ptr] = cur; exp_wr.push_back(cur); pc++; end
                    8'h3E: if (ptr == 511 && !WRAP) begin exp_err = 1; fin = 1; end
                           else begin ptr = (ptr + 1) % 512; cur = m_mem[ptr]; pc++; end
                    8'h3C: if (ptr == 0 && !WRAP) begin exp_err = 1; fin = 1; end
                           else begin ptr = (ptr + 511) % 512; cur = m_mem[ptr]; pc++; end
                    8'h5B: begin
                        if (cur != 0) begin
                            if (stk.size() == SD) begin exp_err = 1; fin = 1; end
                            else begin
                                stk.push_back(pc + 1);
                                if (stk.size() > exp_maxsp) exp_maxsp = stk.size();
                                pc++;
                            end
                        end else begin
                            depth = 0; p = pc + 1; scan = 1;
                            while (scan) begin
                                if (code_mem[p] == 8'h00) begin exp_err = 1; fin = 1; scan = 0; end
                                else if (code_mem[p] == 8'h5B) depth++;
                                else if (code_mem[p] == 8'h5D) begin
                                    if (depth == 0) begin pc = p + 1; scan = 0; end
                                    else depth--;
                                end
                                p++;
                            end
                        end
                    end
                    8'h5D: begin
                        if (stk.size() == 0) begin exp_err = 1; fin = 1; end
                        else if (cur != 0) pc = stk[$];
                        else begin void'(stk.pop_back()); pc++; end
                    end
                    8'h2E: begin exp_tx.push_back(cur & 255); pc++; end
                    8'h2C: begin
                        cur = (idx < 16) ? in_bytes[idx] : 0;
                        idx++; m_mem[ptr] = cur; exp_wr.push_back(cur); pc++;
                    end
                    8'h00: begin exp_done = 1; fin = 1; end
                    default: pc++;
                endcase
            end
        end
        exp_sp = stk.size();
        exp_ptr = ptr;
    endtask

    task automatic do_reset();
        reset = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_prog(string name, int txmin, int txmax, int rxmin, int rxmax);
        int cyc, txwait, rxwait, in_idx, maxsp;
        logic prev_txv, prev_wr;
        logic [7:0] prev_txd;
        logic [8:0] prev_pc;
        model_run();
        do_reset();
        got_tx.delete(); got_wr.delete();
        prev_txv = 0; prev_wr = 0; prev_txd = 0; prev_pc = 0;
        maxsp = 0; in_idx = 0; cyc = 0;
        txwait = int'($urandom_range(txmin, txmax));
        rxwait = int'($urandom_range(rxmin, rxmax));
        while (!(done || error) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (int'(loop_depth) > maxsp) maxsp = int'(loop_depth);
            if (writeRq_array) begin
                chk({name, "/wr_pulse"}, prev_wr, 0);
                got_wr.push_back(int'(dataOut_array));
            end
            if (tx_valid && prev_txv) begin
                chk({name, "/tx_hold"}, tx_data, prev_txd);
                chk({name, "/pc_hold"}, addr_code, prev_pc);
            end
            if (tx_valid) begin
                if (txwait == 0) begin
                    tx_ready = 1'b1;
                    got_tx.push_back(int'(tx_data));
                    txwait = int'($urandom_range(txmin, txmax));
                end else begin
                    tx_ready = 1'b0;
                    txwait--;
                end
            end else tx_ready = 1'($urandom_range(0, 1));
            if (rx_ready) begin
                if (rxwait == 0) begin
                    rx_valid = 1'b1;
                    rx_data  = (in_idx < 16) ? 8'(in_bytes[in_idx]) : 8'h00;
                    in_idx++;
                    rxwait = int'($urandom_range(rxmin, rxmax));
                end else begin
                    rx_valid = 1'b0; rx_data = 8'($urandom); rxwait--;
                end
            end else begin
                rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
            end
            prev_txv = tx_valid; prev_txd = tx_data; prev_pc = addr_code; prev_wr = writeRq_array;
        end
        chk({name, "/halted"}, done | error, 1);
        tx_ready = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, "/done"}, done, exp_done);
        chk({name, "/error"}, error, exp_err);
        chk({name, "/loop_depth"}, loop_depth, exp_sp);
        chk({name, "/max_depth"}, maxsp, exp_maxsp);
        chk({name, "/ptr"}, addr_array, exp_ptr);
        chk({name, "/halt_quiet"}, {writeRq_array, tx_valid, rx_ready}, 0);
        chk({name, "/tx_count"}, got_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            chk($sformatf("%s/tx%0d", name, i), got_tx[i], exp_tx[i]);
        chk({name, "/wr_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk($sformatf("%s/wr%0d", name, i), got_wr[i], exp_wr[i]);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s/cell%0d", name, i), arr_mem[i], m_mem[i]);
        chk({name, "/cell511"}, arr_mem[511], m_mem[511]);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        string pool;
        int accepted, attempts, len;
        bit seen;

        load_prog("");
        init_env(0);
        do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst/addr_code", addr_code, 0);
        chk("rst/addr_array", addr_array, 0);
        chk("rst/dataOut", dataOut_array, 0);
        chk("rst/writeRq", writeRq_array, 0);
        chk("rst/tx", {tx_valid, tx_data}, 0);
        chk("rst/rx_ready", rx_ready, 0);
        chk("rst/flags", {done, error}, 0);
        chk("rst/loop_depth", loop_depth, 0);

        load_prog("+++.");         init_env(0); run_prog("plus3", 0, 0, 0, 0);
        load_prog("++[>+++<-]>."); init_env(0); run_prog("mul", 5, 5, 0, 0);
        load_prog("[[+]+]+.");     init_env(0); run_prog("skipnest", 0, 2, 0, 0);
        load_prog("+[[[");         init_env(0); run_prog("stackfull", 0, 0, 0, 0);
        load_prog("]");            init_env(0); run_prog("stackempty", 0, 0, 0, 0);
        load_prog(",+.");          init_env(0); in_bytes[0] = 8'hFF; run_prog("rx", 0, 1, 3, 3);
        load_prog("<");            init_env(0); run_prog("ptrlow", 0, 0, 0, 0);
        load_prog("-.+.");         init_env(0); run_prog("minuswrap", 0, 2, 0, 0);

        load_prog("+++,");
        init_env(0);
        do_reset();
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rx_ready) seen = 1;
        end
        chk("rxrst/rx_ready_seen", seen, 1);
        repeat (3) @(negedge clk);
        chk("rxrst/pc_in_rx", addr_code, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("rxrst/rx_ready", rx_ready, 0);
        chk("rxrst/addr_code", addr_code, 0);
        chk("rxrst/quiet", {writeRq_array, tx_valid, done, error}, 0);
        reset = 1'b0;

        pool = "+++-->>><[[]].,,x";
        accepted = 0; attempts = 0;
        while (accepted < 25 && attempts < 300) begin
            attempts++;
            load_prog("");
            len = int'($urandom_range(4, 24));
            for (int i = 0; i < len; i++) code_mem[i] = pool[$urandom_range(0, pool.len() - 1)];
            init_env(1);
            model_run();
            if (m_ok) begin
                run_prog($sformatf("rnd%0d", accepted), 0, 3, 0, 3);
                accepted++;
            end
        end
        chk("rnd/accepted", accepted, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
